// File: rtl/timer_p_pkg.sv
// Shared constants for the timer_p peripheral: register offsets,
// CTRL bit positions and default widths.
package timer_p_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int PRE_W_DEF = 16;

    // Word offsets inside the peripheral window
    localparam logic [3:0] CTRL_A  = 4'd0;
    localparam logic [3:0] LOAD_A  = 4'd1;
    localparam logic [3:0] COUNT_A = 4'd2;
    localparam logic [3:0] PRE_A   = 4'd3;
    localparam logic [3:0] STAT_A  = 4'd4;

    // CTRL bit positions
    localparam int EN_B = 0;
    localparam int AR_B = 1;
    localparam int IE_B = 2;

    // CTRL register as seen on the read bus
    function automatic logic [31:0] ctrl_word(input logic [2:0] ctrl);
        return {29'd0, ctrl};
    endfunction

endpackage

// File: rtl/timer_p_prescaler.sv
// Prescaler: divides clk by (prescale+1) while enabled and emits a
// one-cycle tick on the last count of each period.
module timer_prescaler
    import timer_p_pkg::*;
#(
    parameter int PRE_WIDTH = PRE_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic                 tick
);

    logic [PRE_WIDTH-1:0] pcnt;

    // tick is decoded from flops only (enable, counter, divisor)
    assign tick = en && (pcnt == prescale);

    // Count 0..prescale, wrap on tick; held at 0 when disabled or cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (!en || clr) begin
            pcnt <= '0;
        end else if (pcnt == prescale) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_p.sv
// timer_p: memory-mapped down-counting timer with prescaler, optional
// auto-reload and a level interrupt (STATUS.EXP & CTRL.IE).
//
// Bus semantics: there is no valid/ready handshake. wea is a one-cycle
// write strobe that is always accepted on the rising edge; douta returns
// reg[addra] one cycle after addra is presented, regardless of wea, and a
// read that coincides with a write to the same address returns the old value.
module timer_p
    import timer_p_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W_DEF,
    parameter int PRE_WIDTH = PRE_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wea,
    input  logic [3:0]  addra,
    input  logic [31:0] dina,
    output logic [31:0] douta,
    output logic        int_timer
);

    logic [2:0]           ctrl_q;
    logic [CNT_WIDTH-1:0] load_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [PRE_WIDTH-1:0] pre_q;
    logic                 exp_q;

    logic wr_ctrl, wr_load, wr_count, wr_pre, wr_stat;
    logic tick, tick_eff, expire;
    logic [31:0] rdata;

    assign wr_ctrl  = wea && (addra == CTRL_A);
    assign wr_load  = wea && (addra == LOAD_A);
    assign wr_count = wea && (addra == COUNT_A);
    assign wr_pre   = wea && (addra == PRE_A);
    assign wr_stat  = wea && (addra == STAT_A);

    // A CPU write to COUNT swallows a coincident tick, including an expiry
    assign tick_eff = tick && !wr_count;
    assign expire   = tick_eff && (cnt_q == '0);

    timer_prescaler #(
        .PRE_WIDTH(PRE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[EN_B]),
        .clr      (wr_ctrl || wr_pre),
        .prescale (pre_q),
        .tick     (tick)
    );

    // CTRL: CPU write takes priority over the one-shot stop at expiry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
        end else if (wr_ctrl) begin
            ctrl_q <= {dina[IE_B], dina[AR_B], dina[EN_B]};
        end else if (expire && !ctrl_q[AR_B]) begin
            ctrl_q[EN_B] <= 1'b0;
        end
    end

    // LOAD and PRESCALE: plain CPU registers; reload reads the pre-edge LOAD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q <= '0;
            pre_q  <= '0;
        end else begin
            if (wr_load) load_q <= dina[CNT_WIDTH-1:0];
            if (wr_pre)  pre_q  <= dina[PRE_WIDTH-1:0];
        end
    end

    // COUNT: CPU write, else reload on auto-reload expiry, else decrement on tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (wr_count) begin
            cnt_q <= dina[CNT_WIDTH-1:0];
        end else if (expire) begin
            if (ctrl_q[AR_B]) cnt_q <= load_q;
        end else if (tick_eff) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    // STATUS.EXP: expiry set beats a simultaneous write-1-clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q <= 1'b0;
        end else if (expire) begin
            exp_q <= 1'b1;
        end else if (wr_stat && dina[0]) begin
            exp_q <= 1'b0;
        end
    end

    // Read mux; unmapped offsets read zero
    always_comb begin
        rdata = '0;
        case (addra)
            CTRL_A:  rdata = ctrl_word(ctrl_q);
            LOAD_A:  rdata = 32'(load_q);
            COUNT_A: rdata = 32'(cnt_q);
            PRE_A:   rdata = 32'(pre_q);
            STAT_A:  rdata = {31'd0, exp_q};
            default: rdata = '0;
        endcase
    end

    // Registered read port, one-cycle latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            douta <= '0;
        end else begin
            douta <= rdata;
        end
    end

    assign int_timer = exp_q & ctrl_q[IE_B];

endmodule

// File: tb/tb_timer_p.sv
// Bench for timer_p: register table, read latency, one-shot, auto-reload,
// collision cases and asynchronous reset.
module tb_timer_p;
    import timer_p_pkg::*;

    logic        clk;
    logic        rst;
    logic        wea;
    logic [3:0]  addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic        int_timer;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] rexp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    timer_p dut (
        .clk       (clk),
        .rst       (rst),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .douta     (douta),
        .int_timer (int_timer)
    );

    // clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wea   = 1'b1;
        addra = a;
        dina  = d;
        tick_clk();
        wea   = 1'b0;
    endtask

    // push expectation, drive address, pop and compare once douta updates
    task automatic rd_check(input logic [3:0] a, input logic [31:0] expv, input string name);
        logic [31:0] e;
        string       t;
        exp_q.push_back(expv);
        tag_q.push_back(name);
        wea   = 1'b0;
        addra = a;
        tick_clk();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, douta, e);
    endtask

    task automatic wait_int(output int t, input string name);
        for (int n = 0; n < 60 && !int_timer; n++) tick_clk();
        check(name, {31'd0, int_timer}, 32'd1);
        t = cyc;
    endtask

    task automatic wait_cyc(input int target, input string name);
        for (int n = 0; n < 60 && cyc != target; n++) tick_clk();
        check(name, cyc, target);
    endtask

    initial begin
        int t0, t1, t2, t3;

        vecs[0] = '{CTRL_A,  32'hFFFF_FFFA, CTRL_A,  32'h0000_0002, "ctrl_mask"};
        vecs[1] = '{LOAD_A,  32'hDEAD_BEEF, LOAD_A,  32'hDEAD_BEEF, "load_rw"};
        vecs[2] = '{COUNT_A, 32'h1234_5678, COUNT_A, 32'h1234_5678, "count_rw"};
        vecs[3] = '{PRE_A,   32'hABCD_1234, PRE_A,   32'h0000_1234, "pre_trunc"};
        vecs[4] = '{STAT_A,  32'hFFFF_FFFF, STAT_A,  32'h0000_0000, "stat_clr_idle"};
        vecs[5] = '{4'd7,    32'hFFFF_FFFF, 4'd7,    32'h0000_0000, "unmapped7"};
        vecs[6] = '{4'd15,   32'hFFFF_FFFF, 4'd15,   32'h0000_0000, "unmapped15"};
        vecs[7] = '{4'd5,    32'hFFFF_FFFF, LOAD_A,  32'hDEAD_BEEF, "load_untouched"};

        // reset
        rst = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        repeat (2) tick_clk();
        check("rst_douta", douta, 32'd0);
        check("rst_int", {31'd0, int_timer}, 32'd0);
        rst = 1'b1;
        rd_check(COUNT_A, 32'd0, "rst_count");
        rd_check(STAT_A,  32'd0, "rst_stat");

        // register table
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            rd_check(vecs[i].raddr, vecs[i].rexp, vecs[i].name);
        end
        rd_check(COUNT_A, 32'h1234_5678, "count_untouched");
        rd_check(PRE_A,   32'h0000_1234, "pre_untouched");
        rd_check(CTRL_A,  32'h0000_0002, "ctrl_untouched");

        // read latency and read-during-write
        rd_check(4'd5, 32'd0, "lat_prep");
        addra = LOAD_A;
        #1;
        check("lat_before_edge", douta, 32'd0);
        tick_clk();
        check("lat_one_edge", douta, 32'hDEAD_BEEF);
        wr(LOAD_A, 32'h1111_1111);
        check("rdw_old", douta, 32'hDEAD_BEEF);
        rd_check(LOAD_A, 32'h1111_1111, "rdw_new");

        // one-shot: PRESCALE=0, COUNT=3, CTRL=EN|IE
        wr(PRE_A, 32'd0);
        wr(COUNT_A, 32'd3);
        wr(CTRL_A, 32'h5);
        rd_check(COUNT_A, 32'd3, "os_cnt3");
        rd_check(COUNT_A, 32'd2, "os_cnt2");
        rd_check(COUNT_A, 32'd1, "os_cnt1");
        check("os_int_early", {31'd0, int_timer}, 32'd0);
        rd_check(COUNT_A, 32'd0, "os_cnt0");
        check("os_int_4th", {31'd0, int_timer}, 32'd1);
        rd_check(CTRL_A,  32'h4, "os_en_off");
        rd_check(STAT_A,  32'h1, "os_exp");
        rd_check(COUNT_A, 32'd0, "os_no_wrap");
        wr(STAT_A, 32'h1);
        check("os_int_clr", {31'd0, int_timer}, 32'd0);
        rd_check(STAT_A, 32'h0, "os_exp_clr");

        // auto-reload: LOAD=4, PRESCALE=2 -> period 15
        wr(PRE_A, 32'd2);
        wr(LOAD_A, 32'd4);
        wr(COUNT_A, 32'd4);
        wr(CTRL_A, 32'h7);
        t0 = cyc;
        wait_int(t1, "ar_exp1");
        check("ar_first_15", t1 - t0, 32'd15);
        wr(STAT_A, 32'h1);
        check("ar_int_clr", {31'd0, int_timer}, 32'd0);
        wait_int(t2, "ar_exp2");
        check("ar_period_15", t2 - t1, 32'd15);

        // STATUS clear on the expiry edge: set wins
        wr(STAT_A, 32'h1);
        wait_cyc(t2 + 14, "col_align");
        check("col_int_low", {31'd0, int_timer}, 32'd0);
        wr(STAT_A, 32'h1);
        check("col_stat_set_wins", {31'd0, int_timer}, 32'd1);
        t3 = cyc;

        // COUNT write on a tick edge: write wins
        wait_cyc(t3 + 2, "tick_align");
        wr(COUNT_A, 32'd9);
        rd_check(COUNT_A, 32'd9, "col_count_wr");

        // asynchronous reset mid-count with EXP=1
        rd_check(STAT_A, 32'h1, "pre_rst_exp");
        check("pre_rst_int", {31'd0, int_timer}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_int", {31'd0, int_timer}, 32'd0);
        check("arst_douta", douta, 32'd0);
        tick_clk();
        rst = 1'b1;
        rd_check(COUNT_A, 32'd0, "arst_count");
        rd_check(STAT_A,  32'd0, "arst_stat");
        rd_check(CTRL_A,  32'd0, "arst_ctrl");
        repeat (20) tick_clk();
        check("arst_no_expiry", {31'd0, int_timer}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
